// File: rtl/yarvi_reg_scoreboard_pkg.sv
// Shared RV32 decode constants, instruction field helpers and the usage record.
// Combinational helpers only; no latency, no backpressure.
package yarvi_reg_scoreboard_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
  } usage_t;

  function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
    return insn[6:0];
  endfunction

  function automatic logic [4:0] insn_rd(input logic [31:0] insn);
    return insn[11:7];
  endfunction

  function automatic logic [2:0] insn_funct3(input logic [31:0] insn);
    return insn[14:12];
  endfunction

  function automatic logic [4:0] insn_rs1(input logic [31:0] insn);
    return insn[19:15];
  endfunction

  function automatic logic [4:0] insn_rs2(input logic [31:0] insn);
    return insn[24:20];
  endfunction

endpackage

// File: rtl/yarvi_dec_usage.sv
// Register-usage decode: which of rd/rs1/rs2 an instruction reads or writes.
// Purely combinational, 0 cycles; no handshake.
module yarvi_dec_usage
  import yarvi_reg_scoreboard_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic [31:0] i_insn,
  output usage_t      o_usage
);

  logic       w_rd_en;
  logic       w_rs1_en;
  logic       w_rs2_en;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_unused_funct7;

  assign w_rd            = insn_rd(i_insn);
  assign w_rs1           = insn_rs1(i_insn);
  assign w_rs2           = insn_rs2(i_insn);
  assign w_unused_funct7 = ^i_insn[31:25];

  function automatic logic legal(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREGS);
  endfunction

  always_comb begin
    w_rd_en  = 1'b0;
    w_rs1_en = 1'b0;
    w_rs2_en = 1'b0;
    unique case (insn_opcode(i_insn))
      OPC_BRANCH, OPC_STORE: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        w_rd_en  = 1'b1;
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_LOAD: begin
        w_rd_en  = 1'b1;
        w_rs1_en = 1'b1;
      end
      OPC_SYSTEM: begin
        unique case (insn_funct3(i_insn))
          F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
            w_rd_en  = 1'b1;
            w_rs1_en = 1'b1;
          end
          F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: w_rd_en = 1'b1;
          default: ;
        endcase
      end
      OPC_AUIPC, OPC_LUI, OPC_JAL: w_rd_en = 1'b1;
      default: ;
    endcase
  end

  // x0 and indices beyond the implemented file never take part in hazards
  always_comb begin
    o_usage.rd      = (w_rd_en && legal(w_rd)) ? w_rd : 5'd0;
    o_usage.use_rs1 = w_rs1_en && legal(w_rs1);
    o_usage.use_rs2 = w_rs2_en && legal(w_rs2);
  end

endmodule

// File: rtl/yarvi_reg_scoreboard.sv
// Pending-write scoreboard between decode and issue; optional YARVI_SB_WB_BYPASS_EN.
// Latency 1 cycle; in_ready drops on RAW/WAW hazard, flush or a stalled output.
module yarvi_reg_scoreboard
  import yarvi_reg_scoreboard_pkg::*;
#(
  parameter int WB_PORTS = 2,
  parameter int NREGS    = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           in_insn,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [31:0]           out_insn,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic                  out_use_rs1,
  output logic                  out_use_rs2,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [5*WB_PORTS-1:0] wb_rd,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy
);

  logic             r_valid;
  logic [31:0]      r_insn;
  usage_t           r_usage;
  logic [NREGS-1:0] r_busy;

  usage_t           w_usage;
  logic [NREGS-1:0] w_wb_clr;
  logic [NREGS-1:0] w_busy_eff;
  logic [NREGS-1:0] w_busy_nxt;
  logic [31:0]      w_busy32;
  logic             w_hazard;
  logic             w_accept;

  yarvi_dec_usage #(.NREGS(NREGS)) u_dec (
    .i_insn  (in_insn),
    .o_usage (w_usage)
  );

  // x0 never maps to a bit, so a zero index yields an empty mask
  function automatic logic [NREGS-1:0] onehot(input logic [4:0] idx);
    logic [NREGS-1:0] m;
    m = '0;
    for (int i = 1; i < NREGS; i++)
      if (idx == 5'(i)) m[i] = 1'b1;
    return m;
  endfunction

  always_comb begin
    w_wb_clr = '0;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p]) w_wb_clr = w_wb_clr | onehot(wb_rd[5*p +: 5]);
  end

`ifdef YARVI_SB_WB_BYPASS_EN
  assign w_busy_eff = r_busy & ~w_wb_clr;
`else
  assign w_busy_eff = r_busy;
`endif

  always_comb begin
    w_busy32            = '0;
    w_busy32[NREGS-1:0] = w_busy_eff;
  end

  assign w_hazard = (w_usage.use_rs1 && w_busy32[insn_rs1(in_insn)]) ||
                    (w_usage.use_rs2 && w_busy32[insn_rs2(in_insn)]) ||
                    ((w_usage.rd != 5'd0) && w_busy32[w_usage.rd]);

  assign in_ready = !reset && !w_hazard && (!r_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  // Ordering gives set priority over both write-back clear and flush kill
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_clr;
    if (flush && r_valid) w_busy_nxt = w_busy_nxt & ~onehot(r_usage.rd);
    if (w_accept)         w_busy_nxt = w_busy_nxt | onehot(w_usage.rd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_insn  <= INSN_NOP;
      r_usage <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_insn  <= in_insn;
        r_usage <= w_usage;
      end else if (flush || out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_insn    = r_insn;
  assign out_rd      = r_usage.rd;
  assign out_use_rs1 = r_usage.use_rs1;
  assign out_use_rs2 = r_usage.use_rs2;
  assign busy        = r_busy;

endmodule

// File: tb/tb_yarvi_reg_scoreboard.sv
// Scoreboard bench for yarvi_reg_scoreboard: expected issues queued at accept, checked at handshake.
module tb_yarvi_reg_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_insn;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_insn;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_use_rs1;
  logic        out_use_rs2;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        flush;
  logic [31:0] busy;

  always #5 clock = ~clock;

  yarvi_reg_scoreboard #(.WB_PORTS(2), .NREGS(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_insn     (in_insn),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_insn    (out_insn),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_use_rs1 (out_use_rs1),
    .out_use_rs2 (out_use_rs2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .busy        (busy)
  );

  typedef struct packed {
    logic [31:0] insn;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [31:0] ADD3   = {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] ADDI4  = {12'd1, 5'd3, 3'b000, 5'd4, 7'b0010011};
  localparam logic [31:0] SW0    = {7'b0, 5'd0, 5'd0, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] LUI5   = {20'h12345, 5'd5, 7'b0110111};
  localparam logic [31:0] LW6    = {12'd0, 5'd1, 3'b010, 5'd6, 7'b0000011};
  localparam logic [31:0] ADDI9  = {12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011};
  localparam logic [31:0] CSRSI7 = {12'h300, 5'd9, 3'b110, 5'd7, 7'b1110011};
  localparam logic [31:0] ADD10  = {7'b0, 5'd2, 5'd1, 3'b000, 5'd10, 7'b0110011};
  localparam logic [31:0] ADD11  = {7'b0, 5'd2, 5'd1, 3'b000, 5'd11, 7'b0110011};
  localparam logic [31:0] LUI12  = {20'hABCDE, 5'd12, 7'b0110111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] insn, input logic [4:0] rd,
                          input logic u1, input logic u2);
    exp_t e;
    e.insn = insn;
    e.rd   = rd;
    e.u1   = u1;
    e.u2   = u2;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input logic [31:0] insn, input logic [4:0] rd, input logic u1,
                      input logic u2, input bit push, output int stalls);
    in_valid = 1'b1;
    in_insn  = insn;
    stalls   = 0;
    @(negedge clock);
    while (!in_ready && stalls < 20) begin
      stalls++;
      @(negedge clock);
    end
    chk("accept_bound", 32'(in_ready), 32'd1);
    if (push) push_exp(insn, rd, u1, u2);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_issue", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("out_insn", out_insn, e.insn);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_use_rs1", 32'(out_use_rs1), 32'(e.u1));
          chk("out_use_rs2", 32'(out_use_rs2), 32'(e.u2));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_insn   = ADD3;
    out_ready = 1'b1;
    flush     = 1'b0;
    wb_valid  = 2'b00;
    wb_rd     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_insn", out_insn, 32'h0000_0013);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_use", {30'd0, out_use_rs1, out_use_rs2}, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset    = 1'b0;
    in_valid = 1'b0;

    // Independent ALU op issues with one-cycle latency
    @(posedge clock); #1;
    send(ADD3, 5'd3, 1'b1, 1'b1, 1'b1, st);
    @(negedge clock);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_busy", busy, 32'h0000_0008);

    // RAW on x3 released by a write-back on port 0
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_insn  = ADDI4;
    @(negedge clock);
    chk("raw_stall", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd3};
    @(negedge clock);
`ifdef YARVI_SB_WB_BYPASS_EN
    chk("wb_same_cycle", 32'(in_ready), 32'd1);
    push_exp(ADDI4, 5'd4, 1'b1, 1'b0);
    @(posedge clock); #1;
    wb_valid = 2'b00;
`else
    chk("wb_same_cycle", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    wb_valid = 2'b00;
    @(negedge clock);
    chk("wb_next_cycle", 32'(in_ready), 32'd1);
    push_exp(ADDI4, 5'd4, 1'b1, 1'b0);
    @(posedge clock); #1;
`endif
    in_valid = 1'b0;
    @(negedge clock);
    chk("addi_busy", busy, 32'h0000_0010);

    // Both write-back ports clear x4 in the same cycle
    @(posedge clock); #1;
    wb_valid = 2'b11;
    wb_rd    = {5'd4, 5'd4};
    @(posedge clock); #1;
    wb_valid = 2'b00;
    @(negedge clock);
    chk("dual_wb_clear", busy, 32'd0);

    // Store with x0 operands uses nothing and never stalls
    @(posedge clock); #1;
    send(SW0, 5'd0, 1'b0, 1'b0, 1'b1, st);
    chk("sw_stalls", 32'(st), 32'd0);
    @(negedge clock);
    chk("sw_busy", busy, 32'd0);

    // Held LUI x5 is killed by flush
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(LUI5, 5'd5, 1'b0, 1'b0, 1'b0, st);
    @(negedge clock);
    chk("lui_valid", 32'(out_valid), 32'd1);
    chk("lui_busy", busy, 32'h0000_0020);
    chk("lui_rd", 32'(out_rd), 32'd5);
    repeat (2) @(negedge clock);
    chk("hold_insn", out_insn, LUI5);
    chk("hold_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", busy, 32'd0);

    // Accept of LW x6 and a port-1 clear of x6 on the same edge
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_insn   = LW6;
    wb_valid  = 2'b10;
    wb_rd     = {5'd6, 5'd0};
    @(negedge clock);
    chk("lw_ready", 32'(in_ready), 32'd1);
    push_exp(LW6, 5'd6, 1'b1, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    wb_valid = 2'b00;
    @(negedge clock);
    chk("set_wins", busy, 32'h0000_0040);
    @(posedge clock); #1;
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd6};
    @(posedge clock); #1;
    wb_valid = 2'b00;

    // CSRRSI's rs1 field is an immediate, so busy x9 does not stall it
    send(ADDI9, 5'd9, 1'b0, 1'b0, 1'b1, st);
    send(CSRSI7, 5'd7, 1'b0, 1'b0, 1'b1, st);
    chk("csr_stalls", 32'(st), 32'd0);
    @(negedge clock);
    chk("csr_busy", busy, 32'h0000_0280);

    // Back-to-back independent instructions, no bubble
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_insn  = ADD10;
    @(negedge clock);
    chk("b2b_ready0", 32'(in_ready), 32'd1);
    push_exp(ADD10, 5'd10, 1'b1, 1'b1);
    @(posedge clock); #1;
    in_insn = ADD11;
    @(negedge clock);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    chk("b2b_valid0", 32'(out_valid), 32'd1);
    push_exp(ADD11, 5'd11, 1'b1, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("b2b_valid1", 32'(out_valid), 32'd1);
    chk("b2b_busy", busy, 32'h0000_0E80);

    // Reset while an entry is stalled discards it
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(LUI12, 5'd12, 1'b0, 1'b0, 1'b0, st);
    @(negedge clock);
    chk("stall_valid", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    reset    = 1'b1;
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd12};
    @(posedge clock); #1;
    reset    = 1'b0;
    wb_valid = 2'b00;
    @(negedge clock);
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_busy", busy, 32'd0);
    chk("rst2_insn", out_insn, 32'h0000_0013);
    out_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/yarvi_reg_scoreboard.md
YARVI_REG_SCOREBOARD -- requirements
Module: yarvi_reg_scoreboard

Interface
REQ-001 SHALL have parameter WB_PORTS, default 2: number of independent write-back (clear) ports, range 1..4.
REQ-002 SHALL have parameter NREGS, default 32: architectural integer registers tracked, 16 (RV32E) or 32; register index width fixed at 5.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_insn (input, 32) and in_ready (output, 1): decode-side handshake.
REQ-006 SHALL have ports out_valid (output, 1), out_insn (output, 32) and out_ready (input, 1): issue-side handshake.
REQ-007 SHALL have ports out_rd (output, 5), out_use_rs1 (output, 1) and out_use_rs2 (output, 1): registered usage of the issued instruction.
REQ-008 SHALL have ports wb_valid (input, WB_PORTS) and wb_rd (input, 5*WB_PORTS): per-port register-write completion.
REQ-009 SHALL have port flush, input, 1: kills the held output entry.
REQ-010 SHALL have port busy, output, NREGS: current pending-write vector, for debug.

Function
REQ-011 SHALL decode usage combinationally from in_insn as follows; any other opcode uses nothing.
- BRANCH, STORE: rs1, rs2; no rd.
- OP, OP_32: rd, rs1, rs2.
- OP_IMM, OP_IMM_32, JALR, LOAD: rd, rs1.
- SYSTEM with CSRRW/CSRRS/CSRRC: rd, rs1.
- SYSTEM with CSRRWI/CSRRSI/CSRRCI: rd only.
- Other SYSTEM: nothing.
- AUIPC, LUI, JAL: rd only.
REQ-012 SHALL force use_rs1=0 when rs1==0, use_rs2=0 when rs2==0, and rd=0 when the destination field is x0.
REQ-013 SHALL treat any register index >= NREGS as illegal: it is reported as hazard-free and the busy vector is never set for it.
REQ-014 SHALL define hazard = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]) || (rd!=0 && busy[rd]); the rd term is the WAW check.
REQ-015 SHALL drive in_ready = !hazard && (!out_valid || out_ready) && !flush.
REQ-016 SHALL accept on in_valid && in_ready and, on the next edge, load out_insn/out_rd/out_use_rs1/out_use_rs2, assert out_valid and set busy[rd] when rd!=0; latency is 1 cycle and there is no bubble under back-to-back independent traffic.
REQ-017 SHALL clear out_valid on an edge where out_valid && out_ready and no new accept occurs.
REQ-018 SHALL hold out_* stable while out_valid && !out_ready.
REQ-019 SHALL, on each edge, clear busy[wb_rd[p]] for every p with wb_valid[p]; the busy vector is unaffected by wb_rd==0.
REQ-020 SHALL let set win over clear when an accept sets and a write-back clears the same register on the same edge.
REQ-021 SHALL, on flush with out_valid, clear out_valid and clear busy[out_rd] (the killed instruction never writes); a flush has no effect on other busy bits; flush and an accept are mutually exclusive (REQ-015).
REQ-022 SHALL handle several write-back ports naming the same register in one cycle as a single clear.

Reset
REQ-023 SHALL, while reset is high, force out_valid=0, busy=0, out_rd=0, out_use_rs1=0 and out_use_rs2=0, with out_insn set to 0x00000013 (NOP), and SHALL keep in_ready=0.
REQ-024 SHALL have reset override flush, write-backs and accepts on the same edge; a reset mid-stall discards the held entry.

Configuration
REQ-025 SHALL compile a write-back bypass in under macro YARVI_SB_WB_BYPASS_EN: with it defined, registers being cleared by wb_valid this cycle are treated as not busy in REQ-014, so issue happens the same cycle; without it, the hazard check uses registered busy only, adding one cycle of stall after write-back.

Structure
REQ-026 SHALL take opcode, funct3 and field-slice constants from the shared yarvi.h definitions; a usage-record typedef (rd, use_rs1, use_rs2) belongs in the shared package.
REQ-027 SHALL isolate the combinational usage decode (REQ-011..013) in sub-module yarvi_dec_usage, with the scoreboard logic in this module.

Verification
REQ-028 SHALL verify: reset, then ADD x3,x1,x2 with out_ready=1 -> out_valid next cycle, out_rd=3, use_rs1=use_rs2=1, busy=0x00000008.
REQ-029 SHALL verify: busy[3] set, then ADDI x4,x3,1 -> in_ready=0 until wb_valid[0]=1 with wb_rd=3; issue occurs the same cycle with the bypass, one cycle later without.
REQ-030 SHALL verify: SW x0,0(x0) (rs1=rs2=0) -> use_rs1=use_rs2=0, rd=0, no busy change, never stalls.
REQ-031 SHALL verify: out_ready=0 holding LUI x5, then flush -> out_valid=0, busy[5]=0 next cycle.
REQ-032 SHALL verify: accept of LW x6 with wb port1 clearing x6 on the same edge -> busy[6]=1.
REQ-033 SHALL verify: CSRRSI x7 with rs1 field=9 and busy[9]=1 -> no stall, out_use_rs1=0, out_rd=7.
